instr_queue: RTL and testbench

Parametrised successor to the three-lane instruction FIFO. Host writes instruction slices through independent lane enables into a single staging register. When every lane of the staging entry is filled, the whole instruction commits atomically into one shared circular buffer. The buffer is read by the control unit through a first-word-fall-through valid/ready handshake, replacing the per-lane FIFOs and their OR-ed flags.

---
 rtl/tpu_pkg.sv | 21 ++
 rtl/instr_stager.sv | 52 +++++
 rtl/instr_queue.sv | 107 ++++++++++
 tb/tb_instr_queue.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU types: scalar word types plus the sliced instruction layout
// used by the instruction queue and its staging register.
package tpu_pkg;

   localparam int BYTE_WIDTH = 8;

   typedef logic [31:0] word_type;
   typedef logic [15:0] halfword_type;

   localparam int INSTR_SLICE_WIDTH = 16;
   localparam int INSTR_NUM_SLICES  = 5;

   typedef logic [INSTR_SLICE_WIDTH-1:0] instr_slice_type;
   typedef instr_slice_type [INSTR_NUM_SLICES-1:0] instr_type;

   // A margin at or beyond the depth keeps almost_full permanently high
   function automatic int af_threshold(input int depth, input int margin);
      return (margin >= depth) ? 0 : depth - margin;
   endfunction

endpackage

// File: rtl/instr_stager.sv
// Per-lane staging register: collects instruction slices, reports when
// the entry is complete and holds it while the queue cannot take it.
module instr_stager
   import tpu_pkg::*;
#(
   parameter int NUM_SLICES  = INSTR_NUM_SLICES,
   parameter int SLICE_WIDTH = INSTR_SLICE_WIDTH
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_SLICES*SLICE_WIDTH-1:0] slice_in,
   input  logic [NUM_SLICES-1:0]             write_en,
   input  logic                              commit_i,
   output logic                              write_ready,
   output logic                              complete_o,
   output logic [NUM_SLICES*SLICE_WIDTH-1:0] word_o
);

   logic [NUM_SLICES-1:0]                  valid_q, valid_d;
   logic [NUM_SLICES-1:0]                  load;
   logic [NUM_SLICES-1:0][SLICE_WIDTH-1:0] data_q, data_d;
   logic                                   stall_q, stall_d;

   assign write_ready = ~stall_q;
   assign load        = write_en & {NUM_SLICES{~stall_q}};
   assign complete_o  = &(valid_q | load);

   always_comb begin
      data_d = data_q;
      for (int i = 0; i < NUM_SLICES; i++) begin
         if (load[i]) data_d[i] = slice_in[i*SLICE_WIDTH +: SLICE_WIDTH];
      end
   end

   // Merged view lets a commit include slices written on the same edge
   assign word_o  = data_d;
   assign valid_d = commit_i ? '0 : (valid_q | load);
   assign stall_d = complete_o & ~commit_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         data_q  <= '0;
         stall_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         stall_q <= stall_d;
      end
   end

endmodule

// File: rtl/instr_queue.sv
// Instruction queue: sliced staging feeding one circular buffer read
// first-word-fall-through. INSTR_QUEUE_BYPASS_EN enables empty-queue bypass.
module instr_queue
   import tpu_pkg::*;
#(
   parameter int FIFO_DEPTH  = 32,
   parameter int NUM_SLICES  = INSTR_NUM_SLICES,
   parameter int SLICE_WIDTH = INSTR_SLICE_WIDTH,
   parameter int AF_MARGIN   = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_SLICES*SLICE_WIDTH-1:0]   slice_in,
   input  logic [NUM_SLICES-1:0]               write_en,
   output logic                                write_ready,
   output logic [NUM_SLICES*SLICE_WIDTH-1:0]   data_out,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     count,
   output logic                                empty,
   output logic                                full,
   output logic                                almost_full,
   output logic                                overflow_err
);

   localparam int W  = NUM_SLICES * SLICE_WIDTH;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   localparam logic [PW-1:0] LAST    = PW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(af_threshold(FIFO_DEPTH, AF_MARGIN));

   logic [W-1:0]  mem [FIFO_DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          complete, commit, push, pop;
   logic [W-1:0]  word;

   instr_stager #(
      .NUM_SLICES (NUM_SLICES),
      .SLICE_WIDTH(SLICE_WIDTH)
   ) u_stager (
      .clk        (clk),
      .rst        (rst),
      .slice_in   (slice_in),
      .write_en   (write_en),
      .commit_i   (commit),
      .write_ready(write_ready),
      .complete_o (complete),
      .word_o     (word)
   );

   assign empty       = (cnt_q == '0);
   assign full        = (cnt_q == DEPTH_C);
   assign almost_full = (cnt_q >= AF_C);
   assign count       = cnt_q;
   assign overflow_err = ovf_q;

   assign pop    = ~empty & out_ready;
   assign commit = complete & (~full | pop);

`ifdef INSTR_QUEUE_BYPASS_EN
   // An instruction taken straight from staging never touches memory
   assign push      = commit & ~(empty & out_ready);
   assign out_valid = ~empty | commit;
   assign data_out  = ~empty ? mem[rd_q] : (commit ? word : '0);
`else
   assign push      = commit;
   assign out_valid = ~empty;
   assign data_out  = empty ? '0 : mem[rd_q];
`endif

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q | ((|write_en) & ~write_ready);
      if (push) wr_d = (wr_q == LAST) ? '0 : wr_q + PW'(1);
      if (pop)  rd_d = (rd_q == LAST) ? '0 : rd_q + PW'(1);
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_q] <= word;
   end

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue (depth 32 and depth 5).
module tb_instr_queue;

   logic        clk = 1'b0;
   logic        rst;

   logic [79:0] a_slice, a_dout;
   logic [4:0]  a_we;
   logic        a_wrdy, a_oval, a_ordy, a_empty, a_full, a_af, a_ovf;
   logic [5:0]  a_cnt;

   logic [79:0] b_slice, b_dout;
   logic [4:0]  b_we;
   logic        b_wrdy, b_oval, b_ordy, b_empty, b_full, b_af, b_ovf;
   logic [2:0]  b_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   instr_queue u_a (
      .clk(clk), .rst(rst), .slice_in(a_slice), .write_en(a_we),
      .write_ready(a_wrdy), .data_out(a_dout), .out_valid(a_oval),
      .out_ready(a_ordy), .count(a_cnt), .empty(a_empty), .full(a_full),
      .almost_full(a_af), .overflow_err(a_ovf)
   );

   instr_queue #(.FIFO_DEPTH(5)) u_b (
      .clk(clk), .rst(rst), .slice_in(b_slice), .write_en(b_we),
      .write_ready(b_wrdy), .data_out(b_dout), .out_valid(b_oval),
      .out_ready(b_ordy), .count(b_cnt), .empty(b_empty), .full(b_full),
      .almost_full(b_af), .overflow_err(b_ovf)
   );

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [79:0] mk(input int v);
      logic [79:0] r;
      for (int l = 0; l < 5; l++) r[l*16 +: 16] = 16'(v * 16 + l);
      return r;
   endfunction

   task automatic rst_chk(input string t);
      chk({t, "_oval"}, 128'(a_oval), 128'(0));
      chk({t, "_empty"}, 128'(a_empty), 128'(1));
      chk({t, "_full"}, 128'(a_full), 128'(0));
      chk({t, "_af"}, 128'(a_af), 128'(0));
      chk({t, "_ovf"}, 128'(a_ovf), 128'(0));
      chk({t, "_wrdy"}, 128'(a_wrdy), 128'(1));
      chk({t, "_cnt"}, 128'(a_cnt), 128'(0));
      chk({t, "_dout"}, 128'(a_dout), 128'(0));
   endtask

   initial begin
      rst = 1'b1;
      a_slice = '0; a_we = '0; a_ordy = 1'b0;
      b_slice = '0; b_we = '0; b_ordy = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      rst_chk("rst");

      // 1: all lanes in one cycle
      a_slice = 80'h0005_0004_0003_0002_0001;
      a_we = 5'h1f;
      tick();
      a_we = '0;
      chk("t1_oval", 128'(a_oval), 128'(1));
      chk("t1_dout", 128'(a_dout), 128'(80'h0005_0004_0003_0002_0001));
      chk("t1_cnt", 128'(a_cnt), 128'(1));
      a_ordy = 1'b1;
      tick();
      a_ordy = 1'b0;
      chk("t1_pop_empty", 128'(a_empty), 128'(1));

      // 2: scattered lane order with a rewrite of lane 2
      a_we = 5'b10000; a_slice = '0; a_slice[64 +: 16] = 16'h4444;
      tick();
      chk("t2_nv1", 128'(a_oval), 128'(0));
      a_we = 5'b00100; a_slice[32 +: 16] = 16'h2222;
      tick();
      chk("t2_nv2", 128'(a_oval), 128'(0));
      a_we = 5'b00001; a_slice[0 +: 16] = 16'h1010;
      tick();
      chk("t2_nv3", 128'(a_oval), 128'(0));
      a_we = 5'b00110; a_slice[16 +: 16] = 16'h1111;
      a_slice[32 +: 16] = 16'hBEEF;
      tick();
      chk("t2_nv4", 128'(a_oval), 128'(0));
      a_we = 5'b01000; a_slice[48 +: 16] = 16'h3333;
      tick();
      a_we = '0;
      chk("t2_oval", 128'(a_oval), 128'(1));
      chk("t2_dout", 128'(a_dout), 128'(80'h4444_3333_BEEF_1111_1010));
      chk("t2_cnt", 128'(a_cnt), 128'(1));
      a_ordy = 1'b1;
      tick();
      a_ordy = 1'b0;

      // 3: fill, stall, overflow, pop releases the stalled entry
      for (int i = 0; i < 32; i++) begin
         a_slice = mk(i); a_we = 5'h1f;
         tick();
         if (i + 1 == 27) chk("t3_af27", 128'(a_af), 128'(0));
         if (i + 1 == 28) chk("t3_af28", 128'(a_af), 128'(1));
         if (i + 1 == 31) chk("t3_nfull31", 128'(a_full), 128'(0));
      end
      chk("t3_full", 128'(a_full), 128'(1));
      chk("t3_cnt32", 128'(a_cnt), 128'(32));
      a_slice = mk(32); a_we = 5'h1f;
      tick();
      a_we = '0;
      chk("t3_stall_cnt", 128'(a_cnt), 128'(32));
      chk("t3_stall_wrdy", 128'(a_wrdy), 128'(0));
      chk("t3_ovf0", 128'(a_ovf), 128'(0));
      tick();
      chk("t3_hold_wrdy", 128'(a_wrdy), 128'(0));
      a_slice = '0; a_we = 5'b00001;
      tick();
      a_we = '0;
      chk("t3_ovf1", 128'(a_ovf), 128'(1));
      a_ordy = 1'b1;
      #1 chk("t3_head", 128'(a_dout), 128'(mk(0)));
      tick();
      a_ordy = 1'b0;
      chk("t3_pp_cnt", 128'(a_cnt), 128'(32));
      chk("t3_pp_wrdy", 128'(a_wrdy), 128'(1));
      a_ordy = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         #1 chk($sformatf("t3_drain%0d", k), 128'(a_dout), 128'(mk(k)));
         tick();
      end
      a_ordy = 1'b0;
      chk("t3_drained", 128'(a_empty), 128'(1));
      chk("t3_ovf_sticky", 128'(a_ovf), 128'(1));

      // 4: depth-5 instance, commit and pop every cycle
      b_slice = mk(400); b_we = 5'h1f;
      tick();
      for (int k = 1; k < 100; k++) begin
         b_slice = mk(400 + k); b_ordy = 1'b1;
         #1 chk($sformatf("t4_d%0d", k), 128'(b_dout), 128'(mk(399 + k)));
         tick();
         chk($sformatf("t4_c%0d", k), 128'(b_cnt), 128'(1));
      end
      b_we = '0;
      #1 chk("t4_last", 128'(b_dout), 128'(mk(499)));
      tick();
      b_ordy = 1'b0;
      chk("t4_empty", 128'(b_empty), 128'(1));
      chk("t4_ovf", 128'(b_ovf), 128'(0));

      // 5: asynchronous reset mid-stage
      for (int k = 0; k < 7; k++) begin
         a_slice = mk(100 + k); a_we = 5'h1f;
         tick();
      end
      a_slice = mk(150); a_we = 5'b00111;
      tick();
      a_we = '0;
      chk("t5_cnt7", 128'(a_cnt), 128'(7));
      #2 rst = 1'b1;
      #1 rst_chk("t5_async");
      #1 rst = 1'b0;
      tick();
      a_slice = mk(210); a_we = 5'b11000;
      tick();
      a_we = '0;
      chk("t5_no_stale", 128'(a_oval), 128'(0));
      a_we = 5'b00111;
      tick();
      a_we = '0;
      chk("t5_dout", 128'(a_dout), 128'(mk(210)));
      chk("t5_cnt", 128'(a_cnt), 128'(1));
      a_ordy = 1'b1;
      tick();
      a_ordy = 1'b0;

      // 6: empty queue, consumer ready, full write
      a_slice = mk(300); a_we = 5'h1f; a_ordy = 1'b1;
`ifdef INSTR_QUEUE_BYPASS_EN
      #1 chk("t6_byp_oval", 128'(a_oval), 128'(1));
      chk("t6_byp_dout", 128'(a_dout), 128'(mk(300)));
      tick();
      a_we = '0; a_ordy = 1'b0;
      chk("t6_byp_cnt", 128'(a_cnt), 128'(0));
      chk("t6_byp_empty", 128'(a_empty), 128'(1));
`else
      #1 chk("t6_pre_oval", 128'(a_oval), 128'(0));
      tick();
      a_we = '0; a_ordy = 1'b0;
      chk("t6_oval", 128'(a_oval), 128'(1));
      chk("t6_dout", 128'(a_dout), 128'(mk(300)));
      chk("t6_cnt", 128'(a_cnt), 128'(1));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
